// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, response codes,
// FSM state encoding and the alignment rule.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam logic [1:0] ERR_OK         = 2'b00;
  localparam logic [1:0] ERR_MISALIGNED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT    = 2'b10;

  // ISSUE2/WAIT2/WR1/WR2 are only reachable when misaligned splitting is built in.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_ISSUE2,
    ST_WAIT2,
    ST_WR1,
    ST_WR2
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    return (size == SIZE_HALF && offset[0]) ||
           (size == SIZE_WORD && offset != 2'b00) ||
           (size == SIZE_ILLEGAL);
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane handling: store data replication across byte lanes and
// load extraction from a 64-bit window with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [63:0] load_window,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data
);

  logic [63:0] shifted;
  logic [31:0] v;
  logic        sext;

  assign shifted = load_window >> {offset, 3'b000};
  assign v       = shifted[31:0];
  assign sext    = !is_unsigned;

  always_comb begin
    load_data = v;
    unique case (size)
      SIZE_BYTE: load_data = {{24{sext & v[7]}}, v[7:0]};
      SIZE_HALF: load_data = {{16{sext & v[15]}}, v[15:0]};
      default:   load_data = v;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign store_lanes[gi*8 +: 8] =
        (size == SIZE_BYTE) ? store_data[7:0] :
        (size == SIZE_HALF) ? store_data[(gi % 2)*8 +: 8] :
                              store_data[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and the data bus controller.
// Define LSU_MISALIGN_SPLIT_EN to run misaligned half/word accesses as two aligned word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        bus_wd,
  output logic        bus_rd,
  output logic [1:0]  bus_size,
  output logic        bus_unsigned,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [2:0]    LAT_START = 3'(RD_LATENCY - 1);

  lsu_state_t     state_reg, state_next;
  logic           we_reg, we_next;
  logic [1:0]     size_reg, size_next;
  logic           uns_reg, uns_next;
  logic [31:0]    addr_reg, addr_next;
  logic [31:0]    wdata_reg, wdata_next;
  logic [31:0]    data_reg, data_next;
  logic [1:0]     err_reg, err_next;
  logic [2:0]     lat_cnt_reg, lat_cnt_next;
  logic [TW-1:0]  tmo_cnt_reg, tmo_cnt_next;
  logic           split_reg, split_next;
  logic [31:0]    lo_reg, lo_next;
  logic [31:0]    hi_reg, hi_next;

  logic           misaligned;
  logic           bus_phase;
  logic [63:0]    load_window;
  logic [31:0]    store_lanes;
  logic [31:0]    load_data;
  logic [7:0]     byte_mask;
  logic [63:0]    store_shifted;
  logic [63:0]    merged;
  logic [31:0]    word_addr;

  assign misaligned = is_misaligned(size_reg, addr_reg[1:0]);
  assign bus_phase  = (state_reg == ST_ISSUE) || (state_reg == ST_ISSUE2) ||
                      (state_reg == ST_WR1)   || (state_reg == ST_WR2);
  assign word_addr  = {addr_reg[31:2], 2'b00};

  // The second word of a split load arrives last; the first is held in lo_reg.
  assign load_window = (state_reg == ST_WAIT2) ? {bus_rdata, lo_reg} : {32'h0, bus_rdata};

  lsu_align u_align (
    .size        (size_reg),
    .is_unsigned (uns_reg),
    .offset      (addr_reg[1:0]),
    .store_data  (wdata_reg),
    .load_window (load_window),
    .store_lanes (store_lanes),
    .load_data   (load_data)
  );

  // Read-modify-write merge of a misaligned store into the two words read back.
  assign byte_mask     = ((size_reg == SIZE_HALF) ? 8'h03 : 8'h0F) << addr_reg[1:0];
  assign store_shifted = {32'h0, wdata_reg} << {addr_reg[1:0], 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_merge
      assign merged[gi*8 +: 8] = byte_mask[gi] ? store_shifted[gi*8 +: 8]
                                               : (gi < 4 ? lo_reg[(gi % 4)*8 +: 8]
                                                         : hi_reg[(gi % 4)*8 +: 8]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      we_reg      <= 1'b0;
      size_reg    <= 2'b00;
      uns_reg     <= 1'b0;
      addr_reg    <= 32'h0;
      wdata_reg   <= 32'h0;
      data_reg    <= 32'h0;
      err_reg     <= ERR_OK;
      lat_cnt_reg <= 3'd0;
      tmo_cnt_reg <= '0;
      split_reg   <= 1'b0;
      lo_reg      <= 32'h0;
      hi_reg      <= 32'h0;
    end else begin
      state_reg   <= state_next;
      we_reg      <= we_next;
      size_reg    <= size_next;
      uns_reg     <= uns_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      data_reg    <= data_next;
      err_reg     <= err_next;
      lat_cnt_reg <= lat_cnt_next;
      tmo_cnt_reg <= tmo_cnt_next;
      split_reg   <= split_next;
      lo_reg      <= lo_next;
      hi_reg      <= hi_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    we_next      = we_reg;
    size_next    = size_reg;
    uns_next     = uns_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    data_next    = data_reg;
    err_next     = err_reg;
    lat_cnt_next = lat_cnt_reg;
    tmo_cnt_next = tmo_cnt_reg;
    split_next   = split_reg;
    lo_next      = lo_reg;
    hi_next      = hi_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          we_next      = req_we;
          size_next    = req_size;
          uns_next     = req_unsigned;
          addr_next    = req_addr;
          wdata_next   = req_wdata;
          data_next    = 32'h0;
          err_next     = ERR_OK;
          tmo_cnt_next = '0;
          split_next   = 1'b0;
          state_next   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (size_reg == SIZE_ILLEGAL || (misaligned && !SPLIT_EN)) begin
          err_next   = ERR_MISALIGNED;
          state_next = ST_RESP;
        end else begin
          split_next = misaligned;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus_ready) begin
          if (we_reg && !split_reg) begin
            state_next = ST_RESP;
          end else begin
            lat_cnt_next = LAT_START;
            state_next   = ST_WAIT;
          end
        end
      end
      ST_WAIT, ST_WAIT2: begin
        if (lat_cnt_reg != 3'd0) begin
          lat_cnt_next = lat_cnt_reg - 3'd1;
        end else if (state_reg == ST_WAIT && split_reg) begin
          lo_next    = bus_rdata;
          state_next = ST_ISSUE2;
        end else if (state_reg == ST_WAIT2 && we_reg) begin
          hi_next    = bus_rdata;
          state_next = ST_WR1;
        end else begin
          data_next  = load_data;
          state_next = ST_RESP;
        end
      end
      ST_ISSUE2: begin
        if (bus_ready) begin
          lat_cnt_next = LAT_START;
          state_next   = ST_WAIT2;
        end
      end
      ST_WR1:  if (bus_ready) state_next = ST_WR2;
      ST_WR2:  if (bus_ready) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    // Timeout is shared by every strobing state; an accepted strobe restarts the count.
    if (bus_phase) begin
      if (bus_ready) begin
        tmo_cnt_next = '0;
      end else if (TIMEOUT != 0 && tmo_cnt_reg == TMO_LAST) begin
        err_next   = ERR_TIMEOUT;
        state_next = ST_RESP;
      end else begin
        tmo_cnt_next = tmo_cnt_reg + TW'(1);
      end
    end
  end

  always_comb begin
    req_ready    = (state_reg == ST_IDLE);
    resp_valid   = (state_reg == ST_RESP);
    resp_rdata   = resp_valid ? data_reg : 32'h0;
    resp_err     = resp_valid ? err_reg : ERR_OK;
    bus_rd       = ((state_reg == ST_ISSUE) && (!we_reg || split_reg)) || (state_reg == ST_ISSUE2);
    bus_wd       = ((state_reg == ST_ISSUE) && we_reg && !split_reg) ||
                   (state_reg == ST_WR1) || (state_reg == ST_WR2);
    bus_size     = 2'b00;
    bus_unsigned = 1'b0;
    bus_addr     = 32'h0;
    bus_wdata    = 32'h0;
    if (state_reg != ST_IDLE) begin
      bus_unsigned = uns_reg;
      if (split_reg) begin
        bus_size = SIZE_WORD;
        bus_addr = (state_reg == ST_ISSUE2 || state_reg == ST_WAIT2 || state_reg == ST_WR2)
                   ? word_addr + 32'd4 : word_addr;
      end else begin
        bus_size = size_reg;
        bus_addr = addr_reg;
      end
      if (state_reg == ST_WR1)      bus_wdata = merged[31:0];
      else if (state_reg == ST_WR2) bus_wdata = merged[63:32];
      else                          bus_wdata = store_lanes;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (RD_LATENCY=2, TIMEOUT=8).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        bus_wd;
  logic        bus_rd;
  logic [1:0]  bus_size;
  logic        bus_unsigned;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  int checks   = 0;
  int failures = 0;

  // observations from the most recent access
  int          o_resp_cyc;
  logic [31:0] o_rdata;
  logic [1:0]  o_err;
  int          o_rd_acc, o_wd_acc, o_strobe_cyc;
  logic [31:0] o_addr, o_wdata;
  logic [1:0]  o_size;
  logic        o_uns;
  logic        o_ready_k1, o_ready_after;

  always #5 clk = ~clk;

  load_store_unit #(.RD_LATENCY(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_wd(bus_wd), .bus_rd(bus_rd), .bus_size(bus_size), .bus_unsigned(bus_unsigned),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request in IDLE and watches the access until resp_valid (bounded).
  task automatic run_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
    bit seen_strobe = 0;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    o_resp_cyc = -1; o_rdata = 'x; o_err = 'x; o_rd_acc = 0; o_wd_acc = 0; o_strobe_cyc = 0;
    o_addr = 'x; o_wdata = 'x; o_size = 'x; o_uns = 'x; o_ready_k1 = 'x; o_ready_after = 'x;
    for (int k = 1; k <= 40; k++) begin
      tick();
      req_valid = 1'b0;
      if (k == 1) o_ready_k1 = req_ready;
      if (bus_rd || bus_wd) begin
        o_strobe_cyc++;
        if (!seen_strobe) begin
          seen_strobe = 1; o_addr = bus_addr; o_wdata = bus_wdata; o_size = bus_size; o_uns = bus_unsigned;
        end
        if (bus_ready && bus_rd) o_rd_acc++;
        if (bus_ready && bus_wd) o_wd_acc++;
      end
      if (resp_valid) begin
        o_resp_cyc = k; o_rdata = resp_rdata; o_err = resp_err;
        break;
      end
    end
    tick();
    o_ready_after = req_ready;
    $display("txn we=%0b size=%0d uns=%0b addr=%h wdata=%h -> resp_cyc=%0d err=%0d rdata=%h strobes=%0d",
             we, size, uns, addr, wdata, o_resp_cyc, o_err, o_rdata, o_strobe_cyc);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (bus_rd !== 1'b0 || bus_wd !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", bus_rd, bus_wd); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (bus_addr !== 32'h0) begin failures++; $display("FAIL reset_bus_addr got=%h exp=0", bus_addr); end
    rst = 1'b1;
    tick();
    $display("txn reset done");
  endtask

  task automatic test_store_word();
    bus_ready = 1'b1;
    run_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    checks++; if (o_wd_acc !== 1 || o_rd_acc !== 0) begin failures++; $display("FAIL sw_strobes got wd=%0d rd=%0d exp wd=1 rd=0", o_wd_acc, o_rd_acc); end
    checks++; if (o_addr !== 32'h10) begin failures++; $display("FAIL sw_addr got=%h exp=00000010", o_addr); end
    checks++; if (o_size !== 2'b10) begin failures++; $display("FAIL sw_size got=%b exp=10", o_size); end
    checks++; if (o_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", o_wdata); end
    checks++; if (o_resp_cyc !== 3) begin failures++; $display("FAIL sw_latency got=%0d exp=3", o_resp_cyc); end
    checks++; if (o_err !== 2'b00 || o_rdata !== 32'h0) begin failures++; $display("FAIL sw_resp got err=%b rdata=%h exp err=00 rdata=0", o_err, o_rdata); end
    checks++; if (o_ready_k1 !== 1'b0 || o_ready_after !== 1'b1) begin failures++; $display("FAIL sw_req_ready got k1=%b after=%b exp 0/1", o_ready_k1, o_ready_after); end
    checks++; if (bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin failures++; $display("FAIL idle_bus_zero got addr=%h wdata=%h exp 0", bus_addr, bus_wdata); end
  endtask

  task automatic test_loads();
    bus_ready = 1'b1;
    bus_rdata = 32'h80123456;
    run_access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    checks++; if (o_rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_signed got=%h exp=ffffff80", o_rdata); end
    checks++; if (o_resp_cyc !== 5) begin failures++; $display("FAIL lb_latency got=%0d exp=5", o_resp_cyc); end
    checks++; if (o_rd_acc !== 1 || o_wd_acc !== 0) begin failures++; $display("FAIL lb_strobes got rd=%0d wd=%0d exp rd=1 wd=0", o_rd_acc, o_wd_acc); end
    run_access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    checks++; if (o_rdata !== 32'h00000080) begin failures++; $display("FAIL lbu got=%h exp=00000080", o_rdata); end
    checks++; if (o_uns !== 1'b1) begin failures++; $display("FAIL lbu_bus_unsigned got=%b exp=1", o_uns); end
    bus_rdata = 32'h80017F00;
    run_access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    checks++; if (o_rdata !== 32'hFFFF8001) begin failures++; $display("FAIL lh_signed got=%h exp=ffff8001", o_rdata); end
    run_access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    checks++; if (o_rdata !== 32'h00008001) begin failures++; $display("FAIL lhu got=%h exp=00008001", o_rdata); end
    run_access(1'b0, 2'b00, 1'b0, 32'h01, 32'h0);
    checks++; if (o_rdata !== 32'h0000007F) begin failures++; $display("FAIL lb_positive got=%h exp=0000007f", o_rdata); end
    run_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    checks++; if (o_rdata !== 32'h80017F00 || o_err !== 2'b00) begin failures++; $display("FAIL lw got rdata=%h err=%b exp 80017f00/00", o_rdata, o_err); end
  endtask

  task automatic test_misaligned();
    bus_ready = 1'b1;
    bus_rdata = 32'h12345678;
    run_access(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
    checks++; if (o_err !== 2'b01) begin failures++; $display("FAIL lh_misaligned_err got=%b exp=01", o_err); end
    checks++; if (o_strobe_cyc !== 0) begin failures++; $display("FAIL lh_misaligned_strobes got=%0d exp=0", o_strobe_cyc); end
    checks++; if (o_resp_cyc !== 2) begin failures++; $display("FAIL lh_misaligned_latency got=%0d exp=2", o_resp_cyc); end
    checks++; if (o_rdata !== 32'h0) begin failures++; $display("FAIL lh_misaligned_rdata got=%h exp=0", o_rdata); end
    run_access(1'b1, 2'b10, 1'b0, 32'h22, 32'hCAFEF00D);
    checks++; if (o_err !== 2'b01 || o_strobe_cyc !== 0) begin failures++; $display("FAIL sw_misaligned got err=%b strobes=%0d exp 01/0", o_err, o_strobe_cyc); end
    run_access(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    checks++; if (o_err !== 2'b01 || o_strobe_cyc !== 0) begin failures++; $display("FAIL size11 got err=%b strobes=%0d exp 01/0", o_err, o_strobe_cyc); end
  endtask

  task automatic test_store_lanes();
    bus_ready = 1'b1;
    run_access(1'b1, 2'b00, 1'b0, 32'h2, 32'h1A5);
    checks++; if (o_wdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", o_wdata); end
    checks++; if (o_size !== 2'b00 || o_addr !== 32'h2) begin failures++; $display("FAIL sb_size_addr got size=%b addr=%h exp 00/00000002", o_size, o_addr); end
    run_access(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234BEEF);
    checks++; if (o_wdata !== 32'hBEEFBEEF || o_err !== 2'b00) begin failures++; $display("FAIL sh_wdata got=%h err=%b exp beefbeef/00", o_wdata, o_err); end
  endtask

  task automatic test_timeout();
    bus_ready = 1'b0;
    run_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    checks++; if (o_strobe_cyc !== 8) begin failures++; $display("FAIL timeout_strobe_cycles got=%0d exp=8", o_strobe_cyc); end
    checks++; if (o_err !== 2'b10 || o_rdata !== 32'h0) begin failures++; $display("FAIL timeout_resp got err=%b rdata=%h exp 10/0", o_err, o_rdata); end
    checks++; if (o_resp_cyc !== 10) begin failures++; $display("FAIL timeout_latency got=%0d exp=10", o_resp_cyc); end
    bus_ready = 1'b1;
  endtask

  task automatic test_reset_mid_access();
    int resp_seen = 0;
    bus_ready = 1'b1;
    bus_rdata = 32'h55AA55AA;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h80; req_wdata = 32'h0;
    tick();            // accepted -> CHECK
    req_valid = 1'b0;
    tick();            // ISSUE
    tick();            // WAIT
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_idle got ready=%b resp=%b exp 1/0", req_ready, resp_valid); end
    for (int k = 0; k < 6; k++) begin
      tick();
      if (resp_valid) resp_seen++;
    end
    checks++; if (resp_seen !== 0) begin failures++; $display("FAIL rst_mid_no_resp got=%0d exp=0", resp_seen); end
    $display("txn reset during WAIT, resp pulses afterwards=%0d", resp_seen);
  endtask

  task automatic test_back_to_back();
    bus_ready = 1'b1;
    run_access(1'b1, 2'b10, 1'b0, 32'h100, 32'h01020304);
    checks++; if (o_err !== 2'b00 || o_resp_cyc !== 3) begin failures++; $display("FAIL b2b_first got err=%b cyc=%0d exp 00/3", o_err, o_resp_cyc); end
    bus_rdata = 32'h0000FF00;
    run_access(1'b0, 2'b00, 1'b0, 32'h101, 32'h0);
    checks++; if (o_rdata !== 32'hFFFFFFFF || o_resp_cyc !== 5) begin failures++; $display("FAIL b2b_second got rdata=%h cyc=%0d exp ffffffff/5", o_rdata, o_resp_cyc); end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; bus_rdata = 32'h0; bus_ready = 1'b1;
    test_reset();
    test_store_word();
    test_loads();
    test_misaligned();
    test_store_lanes();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
